// File: rtl/hwce_types.sv
// Shared stream types for the HWCE datapath blocks.
package hwce_types;

  typedef struct packed {
    logic       sof;
    logic       eof;
    logic [1:0] user;
  } stream_flags_t;

  typedef enum logic [1:0] {
    WG_IDLE,
    WG_FILL,
    WG_RUN
  } wg_state_e;

endpackage

// File: rtl/hwce_window_gen_if.sv
// Pixel-in / window-out stream handshake for hwce_window_gen.
interface hwce_window_gen_if #(
  parameter int CONV_WIDTH = 16,
  parameter int K          = 3
);
  import hwce_types::*;

  logic                                 valid_in;
  logic                                 ready_in;
  logic signed [CONV_WIDTH-1:0]         pixel_in;
  logic                                 last_in;
  stream_flags_t                        flags_in;
  logic                                 valid_out;
  logic                                 ready_out;
  logic [K*K-1:0][CONV_WIDTH-1:0]       x_window;
  stream_flags_t                        flags_out;

  modport slave (
    input  valid_in, pixel_in, last_in, flags_in, ready_out,
    output ready_in, valid_out, x_window, flags_out
  );

  modport master (
    output valid_in, pixel_in, last_in, flags_in, ready_out,
    input  ready_in, valid_out, x_window, flags_out
  );

endinterface

// File: rtl/hwce_linebuf.sv
// One image row of storage; write and read share the column address.
module hwce_linebuf #(
  parameter  int W     = 16,
  parameter  int DEPTH = 64,
  localparam int AW    = $clog2(DEPTH)
) (
  input  logic          clk,
  input  logic          we,
  input  logic [AW-1:0] addr,
  input  logic [W-1:0]  wdata,
  output logic [W-1:0]  rdata
);

  logic [W-1:0] mem [DEPTH];

  always_ff @(posedge clk)
    if (we) mem[addr] <= wdata;

  // Old value is read out in the same cycle it is overwritten.
  assign rdata = mem[addr];

endmodule

// File: rtl/hwce_window_gen.sv
// Sliding KxK window generator: K-1 line buffers feed a KxK shift window.
module hwce_window_gen import hwce_types::*; #(
  parameter int CONV_WIDTH = 16,
  parameter int K          = 3,
  parameter int MAX_W      = 64
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    enable,
  input  logic                    clear,
  input  logic [$clog2(MAX_W):0]  line_width,
  hwce_window_gen_if.slave        s
);

  localparam int AW = $clog2(MAX_W);
  localparam int LW = AW + 1;
  localparam int RW = $clog2(K);

  wg_state_e                      state_q, state_d;
  logic [LW-1:0]                  col_q, lw_q, lw_eff;
  logic [RW-1:0]                  row_q;
  logic                           valid_q;
  logic [K*K-1:0][CONV_WIDTH-1:0] win_q, win_d, x_q;
  stream_flags_t                  flags_q;
  logic [K-1:0][CONV_WIDTH-1:0]   col_data;
  logic [K-2:0][CONV_WIDTH-1:0]   lb_rd;
  logic                           accept, emit, col_end, row_full;

  assign s.ready_in  = enable & ~rst & ~clear & (s.ready_out | ~valid_q);
  assign accept      = s.valid_in & s.ready_in;
  // The first pixel of a frame must already see the new width.
  assign lw_eff      = (state_q == WG_IDLE) ? line_width : lw_q;
  assign col_end     = (col_q == lw_eff - LW'(1));
  assign row_full    = (row_q == RW'(K-1));
  assign emit        = accept & row_full & (col_q >= LW'(K-1));
  assign s.valid_out = valid_q & ~clear;
  assign s.x_window  = x_q;
  assign s.flags_out = flags_q;

  // Row 0 of the column is the oldest line; row K-1 is the live pixel.
  always_comb begin
    col_data = '0;
    col_data[K-1] = s.pixel_in;
    for (int i = 0; i < K-1; i++) col_data[i] = lb_rd[i];
  end

  for (genvar i = 0; i < K-1; i++) begin : g_lb
    hwce_linebuf #(.W(CONV_WIDTH), .DEPTH(MAX_W)) u_lb (
      .clk   (clk),
      .we    (accept),
      .addr  (col_q[AW-1:0]),
      .wdata (col_data[i+1]),
      .rdata (lb_rd[i])
    );
  end

  always_comb begin
    win_d = win_q;
    for (int r = 0; r < K; r++)
      for (int c = 0; c < K; c++)
        win_d[r*K+c] = (c == K-1) ? col_data[r] : win_q[r*K+c+1];
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      WG_IDLE: if (accept && !s.last_in) state_d = WG_FILL;
      WG_FILL: if (accept) begin
        if (s.last_in)                          state_d = WG_IDLE;
        else if (col_end && row_q == RW'(K-2))  state_d = WG_RUN;
      end
      WG_RUN:  if (accept && s.last_in) state_d = WG_IDLE;
      default: state_d = WG_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= WG_IDLE;
      col_q   <= '0;
      row_q   <= '0;
      lw_q    <= '0;
      valid_q <= 1'b0;
      win_q   <= '0;
      x_q     <= '0;
      flags_q <= '0;
    end else if (clear) begin
      state_q <= WG_IDLE;
      col_q   <= '0;
      row_q   <= '0;
      valid_q <= 1'b0;
      x_q     <= '0;
      flags_q <= '0;
    end else if (enable) begin
      state_q <= state_d;
      if (state_q == WG_IDLE) lw_q <= line_width;
      if (accept) begin
        win_q <= win_d;
        if (s.last_in) begin
          col_q <= '0;
          row_q <= '0;
        end else if (col_end) begin
          col_q <= '0;
          if (!row_full) row_q <= row_q + RW'(1);
        end else begin
          col_q <= col_q + LW'(1);
        end
      end
      if (accept)           valid_q <= emit;
      else if (s.ready_out) valid_q <= 1'b0;
      if (emit) begin
        x_q     <= win_d;
        flags_q <= s.flags_in;
      end
    end
  end

endmodule

// File: tb/tb_hwce_window_gen.sv
// Scoreboard bench for hwce_window_gen: image model predicts windows at acceptance.
module tb_hwce_window_gen;
  import hwce_types::*;

  localparam int CW    = 16;
  localparam int K     = 3;
  localparam int MAX_W = 64;
  localparam int WB    = K*K*CW;

  typedef struct packed {
    logic [WB-1:0] win;
    stream_flags_t flags;
  } exp_t;

  logic                  clk = 1'b0;
  logic                  rst, enable, clear;
  logic [$clog2(MAX_W):0] line_width;

  hwce_window_gen_if #(.CONV_WIDTH(CW), .K(K)) sif ();

  hwce_window_gen #(.CONV_WIDTH(CW), .K(K), .MAX_W(MAX_W)) dut (
    .clk        (clk),
    .rst        (rst),
    .enable     (enable),
    .clear      (clear),
    .line_width (line_width),
    .s          (sif)
  );

  always #5 clk = ~clk;

  int            n_chk = 0, n_err = 0;
  exp_t          exp_q[$];
  int            win_cnt;
  logic [WB-1:0] first_win;
  logic          stall_arm = 1'b0;
  logic [CW-1:0] img [0:7][0:MAX_W-1];
  int            m_row, m_col, tb_lw;

  task automatic chk(input string tag, input logic [255:0] got, input logic [255:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  function automatic stream_flags_t mkflags(input logic [CW-1:0] p, input logic last);
    stream_flags_t f;
    f.sof  = p[0];
    f.eof  = last;
    f.user = p[2:1];
    return f;
  endfunction

  function automatic logic [WB-1:0] mkwin(input int base, input int lw);
    logic [WB-1:0] w = '0;
    for (int r = 0; r < K; r++)
      for (int c = 0; c < K; c++)
        w[(r*K+c)*CW +: CW] = CW'(base + r*lw + c);
    return w;
  endfunction

  task automatic model_reset();
    m_row = 0;
    m_col = 0;
  endtask

  task automatic model_push(input logic [CW-1:0] p, input logic last);
    exp_t e;
    img[m_row][m_col] = p;
    if (m_row >= K-1 && m_col >= K-1) begin
      for (int r = 0; r < K; r++)
        for (int c = 0; c < K; c++)
          e.win[(r*K+c)*CW +: CW] = img[m_row-(K-1)+r][m_col-(K-1)+c];
      e.flags = mkflags(p, last);
      exp_q.push_back(e);
    end
    if (last) model_reset();
    else if (m_col == tb_lw-1) begin
      m_col = 0;
      if (m_row < 7) m_row++;
    end else m_col++;
  endtask

  task automatic send(input int p, input logic last);
    int n = 0;
    @(negedge clk);
    sif.valid_in = 1'b1;
    sif.pixel_in = CW'(p);
    sif.last_in  = last;
    sif.flags_in = mkflags(CW'(p), last);
    #1;
    while (!sif.ready_in && n < 100) begin
      @(negedge clk);
      #1;
      n++;
    end
    if (!sif.ready_in) chk("send_timeout", 0, 1);
    else model_push(CW'(p), last);
    @(posedge clk);
    #1;
    sif.valid_in = 1'b0;
    sif.last_in  = 1'b0;
  endtask

  task automatic send_range(input int base, input int n, input logic last_at_end);
    for (int i = 0; i < n; i++) send(base + i, last_at_end && (i == n-1));
  endtask

  task automatic drain();
    int n = 0;
    while (exp_q.size() != 0 && n < 50) begin
      @(negedge clk);
      #3;
      n++;
    end
    repeat (3) @(negedge clk);
    chk("drain", exp_q.size(), 0);
  endtask

  task automatic start_test(input int lw);
    tb_lw      = lw;
    line_width = ($clog2(MAX_W)+1)'(lw);
    win_cnt    = 0;
    first_win  = '0;
    model_reset();
  endtask

  // Output side: pop and compare on every completed handshake.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      #2;
      if (sif.valid_out && sif.ready_out && enable && !clear && !rst) begin
        if (exp_q.size() == 0) chk("unexpected_window", 1, 0);
        else begin
          e = exp_q.pop_front();
          chk("window", sif.x_window, e.win);
          chk("flags", sif.flags_out, e.flags);
          if (win_cnt == 0) first_win = sif.x_window;
          win_cnt++;
        end
      end
    end
  end

  // Backpressure on the second window of a frame for five cycles.
  initial begin
    forever begin
      @(negedge clk);
      if (stall_arm && sif.valid_out && win_cnt == 1) begin
        sif.ready_out = 1'b0;
        for (int i = 0; i < 5; i++) begin
          #2;
          chk("stall_hold", sif.x_window, exp_q[0].win);
          chk("stall_valid", sif.valid_out, 1);
          chk("stall_ready_in", sif.ready_in, 0);
          @(negedge clk);
        end
        sif.ready_out = 1'b1;
        stall_arm     = 1'b0;
      end
    end
  end

  initial begin
    #400000;
    $display("FAIL watchdog expired");
    $fatal(1);
  end

  initial begin
    rst = 1'b1; enable = 1'b1; clear = 1'b0; line_width = 4;
    sif.valid_in = 1'b0; sif.pixel_in = '0; sif.last_in = 1'b0;
    sif.flags_in = '0; sif.ready_out = 1'b1;
    tb_lw = 4;
    model_reset();
    repeat (2) @(negedge clk);
    #1;
    chk("rst_ready_in", sif.ready_in, 0);
    chk("rst_valid_out", sif.valid_out, 0);
    chk("rst_x_window", sif.x_window, 0);
    chk("rst_flags", sif.flags_out, 0);
    chk("rst_state", dut.state_q, WG_IDLE);
    rst = 1'b0;
    #1;
    chk("ready_after_rst", sif.ready_in, 1);

    // Basic frame, lw=4.
    start_test(4);
    send_range(0, 16, 1'b1);
    drain();
    chk("t1_count", win_cnt, 4);
    chk("t1_first", first_win, mkwin(0, 4));

    // Same stream with a stall on window 2.
    start_test(4);
    stall_arm = 1'b1;
    send_range(0, 16, 1'b1);
    drain();
    chk("t2_count", win_cnt, 4);
    chk("t2_stalled", stall_arm, 0);

    // Second frame must not reuse rows of the first.
    start_test(4);
    send_range(100, 16, 1'b1);
    drain();
    chk("t3_count", win_cnt, 4);
    chk("t3_first", first_win, mkwin(100, 4));

    // Wider line.
    start_test(5);
    send_range(0, 15, 1'b1);
    drain();
    chk("t4_count", win_cnt, 3);
    chk("t4_first", first_win, mkwin(0, 5));

    // Enable low with a window pending: everything frozen.
    start_test(4);
    send_range(0, 11, 1'b0);
    @(negedge clk);
    enable = 1'b0;
    for (int i = 0; i < 3; i++) begin
      #2;
      chk("en_ready_in", sif.ready_in, 0);
      chk("en_valid", sif.valid_out, 1);
      chk("en_hold", sif.x_window, mkwin(0, 4));
      @(negedge clk);
    end
    enable = 1'b1;
    for (int i = 11; i < 16; i++) send(i, i == 15);
    drain();
    chk("t5_count", win_cnt, 4);

    // Clear with a window pending masks valid_out at once.
    start_test(4);
    send_range(0, 11, 1'b0);
    @(negedge clk);
    clear = 1'b1;
    exp_q.delete();
    #1;
    chk("clr_mask", sif.valid_out, 0);
    chk("clr_ready_in", sif.ready_in, 0);
    @(negedge clk);
    clear = 1'b0;
    #1;
    chk("clr_next_valid", sif.valid_out, 0);
    chk("clr_state", dut.state_q, WG_IDLE);

    // Clear after pixel 9, then a full refill is needed.
    start_test(4);
    send_range(0, 10, 1'b0);
    @(negedge clk);
    clear = 1'b1;
    @(negedge clk);
    clear = 1'b0;
    #1;
    chk("clr9_state", dut.state_q, WG_IDLE);
    chk("clr9_valid", sif.valid_out, 0);
    start_test(4);
    send_range(200, 10, 1'b0);
    repeat (3) @(negedge clk);
    chk("clr9_no_early", win_cnt, 0);
    for (int i = 210; i < 216; i++) send(i, i == 215);
    drain();
    chk("t7_count", win_cnt, 4);
    chk("t7_first", first_win, mkwin(200, 4));

    // Reset during RUN discards the pending window.
    start_test(4);
    send_range(0, 11, 1'b0);
    @(negedge clk);
    rst = 1'b1;
    exp_q.delete();
    #1;
    chk("rrun_ready_in", sif.ready_in, 0);
    @(negedge clk);
    #1;
    chk("rrun_valid", sif.valid_out, 0);
    chk("rrun_x_window", sif.x_window, 0);
    chk("rrun_flags", sif.flags_out, 0);
    chk("rrun_state", dut.state_q, WG_IDLE);
    rst = 1'b0;
    start_test(4);
    send_range(300, 16, 1'b1);
    drain();
    chk("t8_count", win_cnt, 4);
    chk("t8_first", first_win, mkwin(300, 4));

    $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
    $finish;
  end

endmodule

// File: doc/hwce_window_gen.md
HWCE_WINDOW_GEN -- requirements
Module: hwce_window_gen

Interface
REQ-001 SHALL have parameter CONV_WIDTH, default 16: pixel width in bits.
REQ-002 SHALL have parameter K, default 3: kernel side; window holds K*K pixels.
REQ-003 SHALL have parameter MAX_W, default 64: maximum line width in pixels.
REQ-004 SHALL have port clk, input, 1: single clock; all logic on rising edge.
REQ-005 SHALL have port rst, input, 1: synchronous, active-high reset.
REQ-006 SHALL have port enable, input, 1: when 0, no state advances.
REQ-007 SHALL have port clear, input, 1: synchronous flush of counters and output register.
REQ-008 SHALL have port line_width, input, $clog2(MAX_W)+1: pixels per line, legal range K..MAX_W, sampled only in IDLE.
REQ-009 SHALL have ports valid_in (in, 1), ready_in (out, 1), pixel_in (in, CONV_WIDTH, signed), last_in (in, 1: final pixel of frame), flags_in (in, stream_flags_t).
REQ-010 SHALL have ports valid_out (out, 1), ready_out (in, 1: driven by the SOP's ready_x_in), x_window (out, K*K x CONV_WIDTH, signed), flags_out (out, stream_flags_t).

Function
REQ-011 SHALL accept a pixel on a cycle with valid_in & ready_in & enable.
REQ-012 SHALL drive ready_in = enable & (ready_out | ~valid_out); accepted pixels are never dropped.
REQ-013 SHALL hold K-1 circular line buffers of MAX_W entries plus a KxK shift-register window; each accepted pixel shifts the window one column and writes the line buffers at index col.
REQ-014 SHALL order x_window[r*K+c] with r=0 oldest row, c=0 leftmost column; index K*K-1 is the pixel just accepted.
REQ-015 SHALL keep col (0..line_width-1) and row (saturating at K-1) counters; col wraps to 0 after line_width-1 and row then increments.
REQ-016 SHALL emit a window only when the accepted pixel has row==K-1 and col>=K-1; latency 1 cycle from acceptance to valid_out.
REQ-017 SHALL hold x_window, flags_out, valid_out stable while valid_out & ~ready_out.
REQ-018 SHALL copy flags_in of the window-completing pixel to flags_out.
REQ-019 SHALL implement FSM IDLE -> FILL (first accepted pixel; line_width latched) -> RUN (row reaches K-1) -> IDLE (pixel with last_in accepted, after its window issues).
REQ-020 SHALL, on last_in, zero col/row; the next frame refills from scratch with no stale-row windows.
REQ-021 SHALL, on clear (priority over acceptance same cycle), zero counters, deassert valid_out next cycle, return to IDLE; line buffer contents need not be cleared.
REQ-022 SHALL mask valid_out combinationally with ~clear, matching the SOP convention.
REQ-023 SHALL freeze all state when enable=0; ready_in=0.

Reset
REQ-024 SHALL on rst: valid_out=0, ready_in=0 while rst high, x_window=0, flags_out=0, counters 0, FSM IDLE.
REQ-025 SHALL treat rst mid-frame like clear, discarding any pending window.

Structure
REQ-026 SHALL take stream_flags_t from the shared hwce_types package; add window_gen FSM state enum there.
REQ-027 SHALL use one sub-module hwce_linebuf (single-port-write/single-read circular buffer, one per row) instantiated K-1 times.

Verification
REQ-028 K=3, line_width=4, pixels 0..15 back-to-back, ready_out=1 -> first window after pixel 10 = {0,1,2,4,5,6,8,9,10}; 4 windows total.
REQ-029 Same stream with ready_out low 5 cycles at window 2 -> window {1,2,3,5,6,7,9,10,11} held stable, ready_in=0, no pixel lost.
REQ-030 last_in on pixel 15, second frame 100..115 -> first window {100,101,102,104,105,106,108,109,110}, none mixing frames.
REQ-031 clear asserted after pixel 9 -> valid_out 0, FSM IDLE, restart needs 11 pixels for first window.
REQ-032 rst pulse during RUN -> all outputs reset values next cycle; enable=0 mid-stream -> counters and outputs frozen.
